// File: rtl/bootram_loader_pkg.sv
// Shared constants for the boot RAM image loader: FSM encodings, error codes
// and the default frame sync marker.
package bootram_loader_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_LEN_LO = 3'd1;
   localparam state_t S_LEN_HI = 3'd2;
   localparam state_t S_DATA   = 3'd3;
   localparam state_t S_WRITE  = 3'd4;
   localparam state_t S_CSUM   = 3'd5;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_LEN     = 2'd1;
   localparam logic [1:0] ERR_CSUM    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/bootram_loader_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled and flags the terminal
// count combinationally so the owner can react on the same edge.
module loader_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 2700000
) (
   input  logic clk,
   input  logic resetn,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)   cnt <= '0;
      else if (clr)  cnt <= '0;
      else if (en)   cnt <= cnt + 1'b1;
   end

   assign tc = en && (cnt == TC_VAL);

endmodule

// File: rtl/bootram_loader.sv
// Byte-stream firmware loader: parses sync/length/payload/checksum frames from
// the UART and writes 32-bit words into the boot RAM while holding the CPU in reset.
module bootram_loader
   import bootram_loader_pkg::*;
#(
   parameter int unsigned ADDR_W         = 10,
   parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
   parameter int unsigned TIMEOUT_CYCLES = 2700000
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              ram_ce,
   output logic              ram_wre,
   output logic [ADDR_W-1:0] ram_ad,
   output logic [31:0]       ram_din,
   output logic              busy,
   output logic              cpu_resetn,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam logic [16:0] DEPTH = 17'(2**ADDR_W);

   state_t            state;
   logic [15:0]       len;
   logic [ADDR_W:0]   idx;
   logic [ADDR_W:0]   idx_nxt;
   logic [1:0]        bcnt;
   logic [23:0]       word;
   logic [7:0]        sum;
   logic              started;
   logic              xfer;
   logic              tm_clr;
   logic              tm_en;
   logic              tm_tc;
   logic [15:0]       n_rx;

   assign xfer    = rx_valid && rx_ready;
   assign n_rx    = {rx_data, len[7:0]};
   assign idx_nxt = idx + 1'b1;
   assign tm_clr  = xfer || (state == S_IDLE);
   assign tm_en   = (state != S_IDLE) && !xfer;

   loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk    (clk),
      .resetn (resetn),
      .clr    (tm_clr),
      .en     (tm_en),
      .tc     (tm_tc)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         len        <= '0;
         idx        <= '0;
         bcnt       <= '0;
         word       <= '0;
         sum        <= '0;
         started    <= 1'b0;
         rx_ready   <= 1'b0;
         ram_ce     <= 1'b0;
         ram_wre    <= 1'b0;
         ram_ad     <= '0;
         ram_din    <= '0;
         busy       <= 1'b0;
         cpu_resetn <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_code   <= ERR_NONE;
      end else begin
         done     <= 1'b0;
         err      <= 1'b0;
         ram_ce   <= 1'b0;
         ram_wre  <= 1'b0;
         rx_ready <= 1'b1;
         started  <= 1'b1;
         // First edge out of reset lets the CPU run whatever image the RAM holds.
         if (!started) cpu_resetn <= 1'b1;

         if (tm_tc) begin
            // WRITE's strobe has already been presented by the time this fires.
            state    <= S_IDLE;
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            busy     <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (xfer && rx_data == SYNC_BYTE) begin
                     state      <= S_LEN_LO;
                     busy       <= 1'b1;
                     cpu_resetn <= 1'b0;
                     err_code   <= ERR_NONE;
                  end
               end
               S_LEN_LO: begin
                  if (xfer) begin
                     len[7:0] <= rx_data;
                     state    <= S_LEN_HI;
                  end
               end
               S_LEN_HI: begin
                  if (xfer) begin
                     len  <= n_rx;
                     idx  <= '0;
                     bcnt <= '0;
                     sum  <= '0;
                     if ({1'b0, n_rx} > DEPTH) begin
                        state      <= S_IDLE;
                        err        <= 1'b1;
                        err_code   <= ERR_LEN;
                        busy       <= 1'b0;
                        cpu_resetn <= 1'b1;
                     end else if (n_rx == 16'd0) begin
                        state <= S_CSUM;
                     end else begin
                        state <= S_DATA;
                     end
                  end
               end
               S_DATA: begin
                  if (xfer) begin
                     sum  <= sum + rx_data;
                     bcnt <= bcnt + 1'b1;
                     // Shift in at the top so byte 0 lands in [7:0] after three bytes.
                     word <= {rx_data, word[23:8]};
                     if (bcnt == 2'd3) begin
                        state    <= S_WRITE;
                        ram_ce   <= 1'b1;
                        ram_wre  <= 1'b1;
                        ram_ad   <= idx[ADDR_W-1:0];
                        ram_din  <= {rx_data, word};
                        rx_ready <= 1'b0;
                     end
                  end
               end
               S_WRITE: begin
                  idx   <= idx_nxt;
                  state <= (16'(idx_nxt) == len) ? S_CSUM : S_DATA;
               end
               S_CSUM: begin
                  if (xfer) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                     if (rx_data == sum) begin
                        done       <= 1'b1;
                        cpu_resetn <= 1'b1;
                     end else begin
                        err      <= 1'b1;
                        err_code <= ERR_CSUM;
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bootram_loader.sv
// Directed bench for bootram_loader: framed loads, length/checksum/timeout
// aborts, a full 1K-word image streamed back to back, and mid-frame reset.
module tb_bootram_loader;

   localparam int ADDR_W = 10;
   localparam int TO     = 100;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_ready;
   logic              ram_ce;
   logic              ram_wre;
   logic [ADDR_W-1:0] ram_ad;
   logic [31:0]       ram_din;
   logic              busy;
   logic              cpu_resetn;
   logic              done;
   logic              err;
   logic [1:0]        err_code;

   always #5 clk = ~clk;

   bootram_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .ram_ce     (ram_ce),
      .ram_wre    (ram_wre),
      .ram_ad     (ram_ad),
      .ram_din    (ram_din),
      .busy       (busy),
      .cpu_resetn (cpu_resetn),
      .done       (done),
      .err        (err),
      .err_code   (err_code)
   );

   wire [50:0] outs = {rx_ready, ram_ce, ram_wre, ram_ad, ram_din, busy,
                       cpu_resetn, done, err, err_code};

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   // Event monitor, sampled mid-cycle.
   int          wcnt = 0, done_cnt = 0, err_cnt = 0, rdy_in_wr = 0, both = 0;
   logic [9:0]  wr_ad  [0:4095];
   logic [31:0] wr_din [0:4095];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ram_ce && ram_wre) begin
         if (wcnt < 4096) begin
            wr_ad[wcnt]  <= ram_ad;
            wr_din[wcnt] <= ram_din;
         end
         wcnt <= wcnt + 1;
         if (rx_ready) rdy_in_wr <= rdy_in_wr + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (err) err_cnt <= err_cnt + 1;
      if (done && err) both <= both + 1;
   end

   // Test frame: two words 0x13 and 0x0B00006F; payload byte sum = 0x8D.
   localparam logic [7:0] F1 [0:10] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00,
                                        8'h00, 8'h6F, 8'h00, 8'h00, 8'h0B};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   // Presents a byte and returns just after the edge that accepted it; rx_valid stays high.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && n < 50) begin
         tick(1);
         n++;
      end
      if (n >= 50) chk("rx_ready_wait", rx_ready, 1);
      tick(1);
   endtask

   task automatic run_f1(input logic [7:0] cs);
      for (int i = 0; i < 11; i++) send_byte(F1[i]);
      send_byte(cs);
      rx_valid = 1'b0;
      tick(3);
   endtask

   task automatic check_f1_writes(input string tag, input int w0);
      chk({tag, "_nwr"}, wcnt - w0, 2);
      chk({tag, "_ad0"}, wr_ad[w0], 10'd0);
      chk({tag, "_din0"}, wr_din[w0], 32'h0000_0013);
      chk({tag, "_ad1"}, wr_ad[w0+1], 10'd1);
      chk({tag, "_din1"}, wr_din[w0+1], 32'h0B00_006F);
   endtask

   initial begin
      int w0, d0, e0, r0, c0, c1, k, bad;

      #3;
      chk("rst_outs", outs, 0);
      @(negedge clk);
      #1;
      resetn = 1'b1;
      tick(2);
      chk("rel_rx_ready", rx_ready, 1);
      chk("rel_cpu_resetn", cpu_resetn, 1);
      chk("rel_busy", busy, 0);

      // 1: good two-word frame
      w0 = wcnt; d0 = done_cnt; e0 = err_cnt; r0 = rdy_in_wr;
      send_byte(8'hA5);
      rx_valid = 1'b0;
      tick(1);
      chk("t1_busy_mid", busy, 1);
      chk("t1_cpurst_mid", cpu_resetn, 0);
      for (int i = 1; i < 11; i++) send_byte(F1[i]);
      send_byte(8'h8D);
      rx_valid = 1'b0;
      tick(3);
      check_f1_writes("t1", w0);
      chk("t1_stall", rdy_in_wr - r0, 0);
      chk("t1_done", done_cnt - d0, 1);
      chk("t1_err", err_cnt - e0, 0);
      chk("t1_cpurst", cpu_resetn, 1);
      chk("t1_busy", busy, 0);
      chk("t1_code", err_code, 0);

      // 2: bad checksum, then a good resend
      w0 = wcnt; d0 = done_cnt; e0 = err_cnt;
      run_f1(8'h00);
      check_f1_writes("t2", w0);
      chk("t2_err", err_cnt - e0, 1);
      chk("t2_done", done_cnt - d0, 0);
      chk("t2_code", err_code, 2);
      chk("t2_cpurst", cpu_resetn, 0);
      chk("t2_busy", busy, 0);
      w0 = wcnt; d0 = done_cnt;
      run_f1(8'h8D);
      check_f1_writes("t2r", w0);
      chk("t2r_done", done_cnt - d0, 1);
      chk("t2r_cpurst", cpu_resetn, 1);
      chk("t2r_code", err_code, 0);

      // 3: N=1025 rejected, then N=0 accepted
      w0 = wcnt; d0 = done_cnt; e0 = err_cnt;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h04);
      rx_valid = 1'b0;
      tick(3);
      chk("t3_err", err_cnt - e0, 1);
      chk("t3_code", err_code, 1);
      chk("t3_cpurst", cpu_resetn, 1);
      chk("t3_busy", busy, 0);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      rx_valid = 1'b0;
      tick(3);
      chk("t3_nwr", wcnt - w0, 0);
      chk("t3z_done", done_cnt - d0, 1);
      chk("t3z_err", err_cnt - e0, 1);
      chk("t3z_code", err_code, 0);

      // 4: stall mid-word until the watchdog fires
      w0 = wcnt; e0 = err_cnt;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22);
      rx_valid = 1'b0;
      k = 0;
      while (k < 200 && !err) begin
         tick(1);
         k++;
      end
      chk("t4_to_cycle", k, TO);
      chk("t4_code", err_code, 3);
      chk("t4_cpurst", cpu_resetn, 0);
      tick(1);
      chk("t4_err_pulse", err, 0);
      chk("t4_busy", busy, 0);
      send_byte(8'h55);
      rx_valid = 1'b0;
      tick(3);
      chk("t4_garbage_busy", busy, 0);
      chk("t4_garbage_code", err_code, 3);
      chk("t4_nwr", wcnt - w0, 0);
      chk("t4_nerr", err_cnt - e0, 1);

      // 5: full 1024-word image, back to back; payload sum is 0 mod 256
      w0 = wcnt; d0 = done_cnt; e0 = err_cnt; r0 = rdy_in_wr;
      c0 = cyc;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04);
      for (int i = 0; i < 1024; i++) begin
         send_byte(8'(i)); send_byte(8'(i >> 8)); send_byte(8'h00); send_byte(8'h00);
      end
      send_byte(8'h00);
      c1 = cyc;
      rx_valid = 1'b0;
      tick(3);
      chk("t5_cycles", c1 - c0, 4100 + 1024);
      chk("t5_nwr", wcnt - w0, 1024);
      bad = 0;
      for (int i = 0; i < 1024; i++)
         if (wr_ad[w0+i] != 10'(i) || wr_din[w0+i] != 32'(i)) bad++;
      chk("t5_seq", bad, 0);
      chk("t5_last_ad", wr_ad[w0+1023], 10'd1023);
      chk("t5_stall", rdy_in_wr - r0, 0);
      chk("t5_done", done_cnt - d0, 1);
      chk("t5_err", err_cnt - e0, 0);
      chk("t5_cpurst", cpu_resetn, 1);

      // 6: reset mid-DATA, then a clean reload
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22);
      rx_valid = 1'b0;
      resetn = 1'b0;
      #1;
      chk("t6_async_outs", outs, 0);
      resetn = 1'b1;
      tick(1);
      chk("t6_rx_ready", rx_ready, 1);
      chk("t6_cpurst", cpu_resetn, 1);
      w0 = wcnt; d0 = done_cnt;
      run_f1(8'h8D);
      check_f1_writes("t6", w0);
      chk("t6_done", done_cnt - d0, 1);
      chk("no_done_err_overlap", both, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
